// File: rtl/bus_fifo.sv
// First-word-fall-through FIFO behind the bus delay line. The delay line cannot be stalled, so words that arrive while the FIFO is full are dropped and latched into a sticky overflow flag.
// Optional BUS_FIFO_LEVEL_EN adds the occupancy outputs level and afull.
module bus_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr
`ifdef BUS_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       afull
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // The status flags depend only on the registered pointers, so in_valid and out_ready have no combinational path to any output.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    assign push = in_valid && !full;
    assign pop  = out_valid && out_ready;

    // NOTE: the storage array has no reset. The empty mask on out_data hides stale contents, and leaving out the reset keeps the array as plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    // NOTE: every state register uses non-blocking assignment, so all of them update together from values taken before the edge.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A drop and a clear in the same cycle leave the flag set.
            if (in_valid && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef BUS_FIFO_LEVEL_EN
    localparam logic [AW:0] AFULL_LEVEL = (AW+1)'(DEPTH - 1);

    assign level = wr_ptr - rd_ptr;
    assign afull = (level >= AFULL_LEVEL);
`endif

endmodule

// File: tb/tb_bus_fifo.sv
// Self-checking bench for bus_fifo. A queue-based reference model is compared against the DUT outputs on every cycle.
// Directed corner cases run first, then a randomized phase.
module tb_bus_fifo;

    localparam int WIDTH = 10;
    localparam int DEPTH = 4;
    localparam int AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             arst_n;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             ovf_clr;
`ifdef BUS_FIFO_LEVEL_EN
    logic [AW:0]      level;
    logic             afull;
`endif

    bus_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
`ifdef BUS_FIFO_LEVEL_EN
        ,
        .level     (level),
        .afull     (afull)
`endif
    );

    always #5 clk = ~clk;

    int               checks   = 0;
    int               failures = 0;
    logic [WIDTH-1:0] model_q[$];
    logic             model_ovf;
    int               popped_words;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compares every output with the model. Called only when no clock edge is near.
    task automatic check_outputs();
        int n;
        n = model_q.size();
        check("empty",     32'(empty),     32'(n == 0));
        check("full",      32'(full),      32'(n == DEPTH));
        check("in_ready",  32'(in_ready),  32'(n != DEPTH));
        check("out_valid", 32'(out_valid), 32'(n != 0));
        check("out_data",  32'(out_data),  (n != 0) ? 32'(model_q[0]) : 32'd0);
        check("overflow",  32'(overflow),  32'(model_ovf));
`ifdef BUS_FIFO_LEVEL_EN
        check("level",     32'(level),     32'(n));
        check("afull",     32'(afull),     32'(n >= DEPTH - 1));
`endif
    endtask

    // One clock cycle: drive the inputs at the negedge, check the outputs, then apply the FIFO rules to the model at the posedge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy, input logic clr);
        bit was_full;
        bit was_empty;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        check_outputs();
        @(posedge clk);
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        if (ordy && !was_empty) begin
            void'(model_q.pop_front());
            popped_words++;
        end
        if (iv && !was_full) model_q.push_back(id);
        if (iv && was_full) model_ovf = 1'b1;
        else if (clr)       model_ovf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        arst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; ovf_clr = 1'b0;
        model_ovf = 1'b0;
        popped_words = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outputs();
        arst_n = 1'b1;
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);            // pop while empty is ignored

        // Fill 0x001..0x004, then check full.
        for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
        step(0, '0, 0, 0);
        // A word offered while full is dropped and sets overflow.
        step(1, 10'h3FF, 0, 0);
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);            // clear
        step(0, '0, 0, 0);
        step(1, 10'h3FF, 0, 0);       // drop again
        step(1, 10'h3FF, 0, 1);       // the drop wins over the clear
        step(0, '0, 0, 0);
        step(0, '0, 0, 1);
        // Drain: the words come out as 1..4, and 0x3FF never appears.
        for (int i = 0; i < 6; i++) step(0, '0, 1, 0);

        // Push and pop while empty: only the push takes effect.
        step(1, 10'h0AA, 1, 0);
        step(0, '0, 0, 0);
        // Push and pop while full: only the pop takes effect.
        for (int i = 0; i < 3; i++) step(1, WIDTH'(10'h100 + i), 0, 0);
        step(1, 10'h155, 1, 0);
        step(0, '0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        // Hold 2 words, then stream 20 words while popping; the pointers wrap several times.
        step(1, 10'h201, 0, 0);
        step(1, 10'h202, 0, 0);
        for (int i = 0; i < 20; i++) step(1, WIDTH'(10'h210 + i), 1, 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1, 0);

        // Assert reset in the middle of a cycle with 2 words held and overflow set.
        for (int i = 0; i < 5; i++) step(1, WIDTH'(10'h050 + i), 0, 0);
        for (int i = 0; i < 2; i++) step(0, '0, 1, 0);
        in_valid = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        arst_n = 1'b1;
        step(1, 10'h123, 0, 0);       // first word after release is accepted
        step(0, '0, 0, 0);
        step(0, '0, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 60), WIDTH'($urandom), ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 10));
        end
        for (int i = 0; i < DEPTH + 1; i++) step(0, '0, 1, 1);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: a stalled run still ends with a failure report and the summary line.
    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
